wb_stage: RTL
=============

# wb_stage

Writeback stage of the RV32 core pipeline, directly downstream of the memory stage. It accepts one completed memory-stage result per cycle over a valid/ready handshake and registers it. It then produces the register-file write (including load byte/half extraction and sign/zero extension), the forwarding bus and the retire count. Memory exceptions are converted into a held trap request with an RISC-V mcause code.

## Interface
Parameters:
- DATA_W, 32, datapath width (only 32 supported)
- ADDR_W, 32, PC width

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- mem_valid_i  in  1  memory-stage result valid
- mem_ready_o  out  1  stage can accept a result this cycle
- mem_data_i  in  DATA_W  load: raw aligned 32-bit word; otherwise: final result
- mem_pc_i  in  ADDR_W  PC of the instruction
- mem_rd_i  in  5  destination register
- mem_rd_we_i  in  1  instruction writes rd
- mem_is_load_i / mem_is_store_i  in  1 each  operation class
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_i  in  1  zero-extend load
- mem_byte_off_i  in  2  address[1:0] of the load
- mem_exc_i  in  1  memory exception
- mem_exc_type_i  in  2  00 misaligned, 01 page fault, 10 access fault, 11 reserved
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  DATA_W  write data
- fwd_valid_o / fwd_rd_o / fwd_data_o  out  1/5/DATA_W  forwarding bus; mirrors rf write
- trap_o  out  1  trap request to CSR unit
- trap_cause_o  out  5  mcause code
- trap_pc_o  out  ADDR_W  faulting PC (mepc)
- trap_ack_i  in  1  CSR unit accepted trap
- instret_o  out  64  retired-instruction count

## Operation
- States: WB_RUN, WB_TRAP.
- In WB_RUN:
  - mem_ready_o = 1.
  - A handshake (mem_valid_i && mem_ready_o) captures all mem_* fields into a one-entry register and sets valid_q.
  - Otherwise valid_q clears. There is no stall input from downstream.
- Output from a registered non-exception entry:
  - rf_we_o = valid_q && rd_we_q && !exc_q && rd_q != 0.
  - rf_wdata_o is the result after load extraction.
  - The fwd_* bus equals the rf_* bus.
- Load extraction (is_load_q):
  - Byte: data[8*off+7 : 8*off].
  - Half: off[1] selects bits [31:16] or [15:0]. off[0] is ignored; alignment is the memory stage's job.
  - Word: unchanged.
  - Sign-extend unless unsigned_q.
- Non-loads pass data through unchanged.
- Captured exception:
  - No rf write.
  - Transition to WB_TRAP. trap_o = 1 with trap_cause_o/trap_pc_o from the captured entry.
  - mem_ready_o = 0.
- Cause map:
  - Misaligned: load 4, store 6.
  - Access fault: load 5, store 7.
  - Page fault: load 13, store 15.
  - Reserved type: load 5, store 7.
  - Non-load/store with exception: 7.
- In WB_TRAP:
  - trap_o and its fields hold until trap_ack_i.
  - Ack returns to WB_RUN on the next edge and clears valid_q. mem_ready_o = 1 from that cycle.
- instret increments by 1 for each captured entry with !exc_q, one cycle after capture. Wraps 2^64−1 → 0.

## Timing
- Latency: handshake at edge N → rf_we_o/fwd valid during cycle N+1 (combinational from registers).
- Trap: exception captured at edge N → trap_o high in cycle N+1. Ack sampled at edge M → trap_o low in cycle M+1.
- Ack in the first trap cycle is legal: trap_o is high for exactly one cycle.
- trap_ack_i is ignored in WB_RUN.
- Back-to-back handshakes every cycle give one write per cycle.
- Reset, including mid-trap:
  - State → WB_RUN, valid_q = 0.
  - All outputs 0 except mem_ready_o = 1.
  - instret_o = 0.

## Configuration
- WB_INSTRET_EN defined: 64-bit retire counter as above.
- WB_INSTRET_EN undefined: no counter, instret_o tied to 0.

## Test plan
- LB x5, unsigned_i = 0, data 0x8012_34F0, off 3 → rf_we_o = 1, waddr 5, wdata 0xFFFF_FF80 one cycle after handshake.
- LHU, data 0xBEEF_1234, off 2 → wdata 0x0000_BEEF. Same with LH → 0xFFFF_BEEF.
- ALU result 0xDEAD_BEEF to rd = 0 with rd_we = 1 → rf_we_o = 0 and fwd_valid_o = 0. instret still increments.
- Store page fault at PC 0x8000_0100 → trap_o = 1, cause 15, trap_pc_o 0x8000_0100, mem_ready_o = 0.
  - Hold 3 cycles, ack → trap_o low next cycle, ready high. No rf write; instret unchanged.
- 10 back-to-back valid results → 10 consecutive rf writes and instret_o = 10.
  - Assert rst_ni low mid-stream → all outputs 0 and instret_o = 0 immediately.
- Load misaligned with ack in the same cycle trap_o rises → trap_o high exactly one cycle, cause 4.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: RV32 writeback stage.
// Registers one memory-stage result per cycle, performs load byte/half
// extraction with sign/zero extension, drives the register-file write and
// the forwarding bus, and turns memory exceptions into a held trap request.
// Optional feature macro: WB_INSTRET_EN enables the 64-bit retire counter;
// without it instret_o is tied to zero.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_pc_i,
  input  logic [4:0]        mem_rd_i,
  input  logic              mem_rd_we_i,
  input  logic              mem_is_load_i,
  input  logic              mem_is_store_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [1:0]        mem_byte_off_i,
  input  logic              mem_exc_i,
  input  logic [1:0]        mem_exc_type_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              fwd_valid_o,
  output logic [4:0]        fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              trap_o,
  output logic [4:0]        trap_cause_o,
  output logic [ADDR_W-1:0] trap_pc_o,
  input  logic              trap_ack_i,
  output logic [63:0]       instret_o
);

  typedef enum logic {WB_RUN = 1'b0, WB_TRAP = 1'b1} wb_state_e;

  wb_state_e state_q, state_d;

  // one-entry result register
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;
  logic [4:0]        rd_q;
  logic              rd_we_q;
  logic              is_load_q;
  logic              is_store_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [1:0]        off_q;
  logic              exc_q;
  logic [1:0]        exc_type_q;

  logic              hs;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [4:0]        cause;

  assign hs = mem_valid_i && mem_ready_o;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= WB_RUN;
    else         state_q <= state_d;
  end

  // next state and handshake ready; trap entered on the capture edge so
  // trap_o rises in the cycle right after the faulting entry is taken
  always_comb begin
    state_d     = state_q;
    mem_ready_o = 1'b0;
    case (state_q)
      WB_RUN: begin
        mem_ready_o = 1'b1;
        if (hs && mem_exc_i) state_d = WB_TRAP;
      end
      WB_TRAP: begin
        if (trap_ack_i) state_d = WB_RUN;
      end
      default: state_d = WB_RUN;
    endcase
  end

  // capture register: loads every RUN cycle, frozen while a trap is held
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      off_q      <= '0;
      exc_q      <= 1'b0;
      exc_type_q <= '0;
    end else if (state_q == WB_RUN) begin
      valid_q <= hs;
      if (hs) begin
        data_q     <= mem_data_i;
        pc_q       <= mem_pc_i;
        rd_q       <= mem_rd_i;
        rd_we_q    <= mem_rd_we_i;
        is_load_q  <= mem_is_load_i;
        is_store_q <= mem_is_store_i;
        size_q     <= mem_size_i;
        unsigned_q <= mem_unsigned_i;
        off_q      <= mem_byte_off_i;
        exc_q      <= mem_exc_i;
        exc_type_q <= mem_exc_type_i;
      end
    end else if (trap_ack_i) begin
      valid_q <= 1'b0;
    end
  end

  // load extraction; half uses off[1] only, alignment checked upstream
  always_comb begin
    ld_byte = data_q[7:0];
    case (off_q)
      2'd1:    ld_byte = data_q[15:8];
      2'd2:    ld_byte = data_q[23:16];
      2'd3:    ld_byte = data_q[31:24];
      default: ld_byte = data_q[7:0];
    endcase
    ld_half = off_q[1] ? data_q[31:16] : data_q[15:0];
    wdata   = data_q;
    if (is_load_q) begin
      case (size_q)
        2'b00:   wdata = {{24{!unsigned_q && ld_byte[7]}}, ld_byte};
        2'b01:   wdata = {{16{!unsigned_q && ld_half[15]}}, ld_half};
        default: wdata = data_q;
      endcase
    end
  end

  // exception type to mcause; reserved type reported as access fault
  always_comb begin
    cause = 5'd7;
    if (is_load_q) begin
      case (exc_type_q)
        2'b00:   cause = 5'd4;
        2'b01:   cause = 5'd13;
        default: cause = 5'd5;
      endcase
    end else if (is_store_q) begin
      case (exc_type_q)
        2'b00:   cause = 5'd6;
        2'b01:   cause = 5'd15;
        default: cause = 5'd7;
      endcase
    end
  end

  assign rf_we_o      = valid_q && rd_we_q && !exc_q && (rd_q != 5'd0);
  assign rf_waddr_o   = rd_q;
  assign rf_wdata_o   = wdata;
  assign fwd_valid_o  = rf_we_o;
  assign fwd_rd_o     = rf_waddr_o;
  assign fwd_data_o   = rf_wdata_o;
  assign trap_o       = (state_q == WB_TRAP);
  assign trap_cause_o = trap_o ? cause : 5'd0;
  assign trap_pc_o    = trap_o ? pc_q : '0;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // retire count: each non-exception entry counts the cycle after capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 instret_q <= '0;
    else if (valid_q && !exc_q)  instret_q <= instret_q + 64'd1;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'd0;
`endif

endmodule
